// File: rtl/eva_ahb_sram_slv.sv
// AHB-Lite SRAM slave: 2**ADDR_W x 32-bit array, WAIT_CYC wait states per OKAY data phase,
// two-cycle ERROR response for out-of-range, misaligned or illegal-size transfers.
module eva_ahb_sram_slv #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic        hclk,
  input  logic        hrest,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] WAIT_INIT  = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;
  localparam int         DEPTH      = 1 << ADDR_W;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic                r_hready;
  logic [1:0]          r_hresp;
  logic                r_dp_vld;
  logic                r_dp_write;
  logic [ADDR_W-1:0]   r_dp_addr;
  logic [3:0]          r_dp_be;
  logic [31:0]         r_mem [0:DEPTH-1];

  logic                w_accept;
  logic                w_err;
  logic                w_hi_bad;
  logic [3:0]          w_be;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_commit;

  assign w_accept = hsel & hready_in & ((htrans == 2'b10) | (htrans == 2'b11));
  assign w_hi_bad = (haddr >> (ADDR_W + 2)) != 32'd0;
  assign w_err    = w_hi_bad
                  | (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  assign w_idx    = haddr[ADDR_W+1:2];

  always_comb begin
    w_be = 4'b0000;
    case (hsize)
      3'd0:    w_be = 4'b0001 << haddr[1:0];
      3'd1:    w_be = haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Address phases are only sampled in states that drive hready_out high.
  always_ff @(posedge hclk) begin
    if (hrest) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_dp_vld <= 1'b0;
      r_hready <= 1'b1;
      r_hresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE, S_ERR2: begin
          r_state  <= S_IDLE;
          r_dp_vld <= 1'b0;
          r_hready <= 1'b1;
          r_hresp  <= RESP_OKAY;
          if (w_accept) begin
            if (w_err) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= RESP_ERROR;
            end else begin
              r_dp_vld   <= 1'b1;
              r_dp_write <= hwrite;
              r_dp_addr  <= w_idx;
              r_dp_be    <= w_be;
              if (WAIT_CYC > 0) begin
                r_state  <= S_WAIT;
                r_cnt    <= WAIT_INIT;
                r_hready <= 1'b0;
              end
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= RESP_ERROR;
        end
        default: begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= RESP_OKAY;
        end
      endcase
    end
  end

  // Commit at the completing edge so a read issued in the same cycle sees the new word.
  assign w_commit = r_hready & r_dp_vld & r_dp_write & ~hrest;

  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_dp_be[b]) r_mem[r_dp_addr][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hready_out = r_hready;
  assign hresp      = r_hresp;
  assign hrdata     = (~hrest & r_hready & r_dp_vld & ~r_dp_write) ? r_mem[r_dp_addr] : 32'd0;

endmodule

// File: tb/tb_eva_ahb_sram_slv.sv
// Scoreboard bench: three slave instances (WAIT_CYC 0/3/5) exercised one at a time on a shared bus.
module tb_eva_ahb_sram_slv;

  typedef struct {
    logic [1:0]  resp;
    int          waits;
    logic        rd;
    logic [31:0] rdata;
    logic        abort;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hrest;
  logic [2:0]  hsel_v;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        force_lo;
  logic [2:0]  hready_in_v;
  logic        hready_v  [3];
  logic [1:0]  hresp_v   [3];
  logic [31:0] hrdata_v  [3];

  int   cur;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic rst_q = 1'b0;

  always #5 hclk = ~hclk;
  always @(posedge hclk) rst_q <= hrest;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : (g == 1) ? 3 : 5;
    assign hready_in_v[g] = hready_v[g] & ~force_lo;
    eva_ahb_sram_slv #(.ADDR_W(8), .WAIT_CYC(WC)) u_dut (
      .hclk       (hclk),
      .hrest      (hrest),
      .hsel       (hsel_v[g]),
      .htrans     (htrans),
      .hwrite     (hwrite),
      .haddr      (haddr),
      .hsize      (hsize),
      .hwdata     (hwdata),
      .hready_in  (hready_in_v[g]),
      .hready_out (hready_v[g]),
      .hresp      (hresp_v[g]),
      .hrdata     (hrdata_v[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s (inst %0d, t=%0t): got 0x%08h, expected 0x%08h", name, cur, $time, act, req);
    end
  endtask

  // Monitor: tracks data phases from bus activity, compares against the queue on completion.
  logic        m_pend = 1'b0;
  int          m_low  = 0;
  logic        m_rdy;
  logic [1:0]  m_rsp;
  logic [31:0] m_rd;
  exp_t        m_e;

  always @(negedge hclk) begin
    m_rdy = hready_v[cur];
    m_rsp = hresp_v[cur];
    m_rd  = hrdata_v[cur];
    if (rst_q) begin
      if (m_pend) begin
        if (exp_q.size() > 0) begin
          m_e = exp_q.pop_front();
          chk("abort_flag", 32'(m_e.abort), 32'd1);
        end else begin
          chk("abort_entry", 32'd0, 32'd1);
        end
      end
      m_pend = 1'b0;
      chk("rst_hready", 32'(m_rdy), 32'd1);
      chk("rst_hresp", 32'(m_rsp), 32'd0);
      chk("rst_hrdata", m_rd, 32'd0);
    end else if (m_pend) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dphase", 32'd0, 32'd1);
        m_pend = 1'b0;
      end else if (!m_rdy) begin
        m_low++;
        chk("wait_hresp", 32'(m_rsp), 32'(exp_q[0].resp));
        chk("wait_hrdata", m_rd, 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk("dphase_not_aborted", 32'(m_e.abort), 32'd0);
        chk("dphase_waits", 32'(m_low), 32'(m_e.waits));
        chk("dphase_hresp", 32'(m_rsp), 32'(m_e.resp));
        chk("dphase_hrdata", m_rd, m_e.rd ? m_e.rdata : 32'd0);
        m_pend = 1'b0;
      end
    end else begin
      chk("idle_hready", 32'(m_rdy), 32'd1);
      chk("idle_hresp", 32'(m_rsp), 32'd0);
      chk("idle_hrdata", m_rd, 32'd0);
    end
    if (!hrest && hsel_v[cur] && htrans[1] && hready_in_v[cur]) begin
      m_pend = 1'b1;
      m_low  = 0;
    end
  end

  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge hclk);
      ok = hready_in_v[cur];
      @(posedge hclk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [1:0] resp, input int waits,
                      input logic [31:0] rdat, input logic abrt);
    exp_t e;
    hsel_v       = 3'b000;
    hsel_v[cur]  = 1'b1;
    htrans       = 2'b10;
    hwrite       = wr;
    haddr        = addr;
    hsize        = sz;
    e = '{resp: resp, waits: waits, rd: (!wr && resp == 2'b00), rdata: rdat, abort: abrt};
    exp_q.push_back(e);
    wait_accept();
    hwdata = wr ? wd : 32'd0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd,
                    input logic [1:0] resp, input int waits);
    xfer(1'b1, addr, sz, wd, resp, waits, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] sz, input logic [1:0] resp,
                    input int waits, input logic [31:0] rdat);
    xfer(1'b0, addr, sz, 32'd0, resp, waits, rdat, 1'b0);
  endtask

  task automatic idle();
    hsel_v = 3'b000;
    htrans = 2'b00;
    wait_accept();
    hwdata = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = 0; hsel_v = 3'b000; htrans = 2'b00; hwrite = 1'b0; haddr = 32'd0;
    hsize = 3'd0; hwdata = 32'd0; force_lo = 1'b0; hrest = 1'b1;
    repeat (3) @(posedge hclk);
    #1 hrest = 1'b0;

    // WAIT_CYC = 0: word/byte/half writes with read-back, errors, back-to-back
    wr(32'h10, 3'd2, 32'hDEADBEEF, 2'b00, 0);
    rd(32'h10, 3'd2, 2'b00, 0, 32'hDEADBEEF);
    wr(32'h11, 3'd0, 32'h0000AB00, 2'b00, 0);
    rd(32'h10, 3'd2, 2'b00, 0, 32'hDEADABEF);
    wr(32'h12, 3'd1, 32'h12340000, 2'b00, 0);
    rd(32'h10, 3'd2, 2'b00, 0, 32'h1234ABEF);
    wr(32'h13, 3'd0, 32'h77000000, 2'b00, 0);
    rd(32'h12, 3'd1, 2'b00, 0, 32'h7734ABEF);
    wr(32'h00, 3'd2, 32'h01020304, 2'b00, 0);
    wr(32'h402, 3'd2, 32'hFFFFFFFF, 2'b01, 1);
    wr(32'h400, 3'd2, 32'hFFFFFFFF, 2'b01, 1);
    wr(32'h02, 3'd2, 32'hFFFFFFFF, 2'b01, 1);
    wr(32'h01, 3'd1, 32'hFFFFFFFF, 2'b01, 1);
    wr(32'h00, 3'd3, 32'hFFFFFFFF, 2'b01, 1);
    rd(32'h00, 3'd2, 2'b00, 0, 32'h01020304);
    rd(32'h402, 3'd2, 2'b01, 1, 32'd0);
    wr(32'h20, 3'd2, 32'hA5A50001, 2'b00, 0);
    rd(32'h20, 3'd2, 2'b00, 0, 32'hA5A50001);
    wr(32'h24, 3'd2, 32'h5A5A0002, 2'b00, 0);
    rd(32'h24, 3'd2, 2'b00, 0, 32'h5A5A0002);
    idle();

    // WAIT_CYC = 3: wait states, read accepted in ERR2, hready_in low ignored
    cur = 1;
    wr(32'h10, 3'd2, 32'hCAFEF00D, 2'b00, 3);
    rd(32'h10, 3'd2, 2'b00, 3, 32'hCAFEF00D);
    wr(32'h403, 3'd2, 32'hFFFFFFFF, 2'b01, 1);
    rd(32'h10, 3'd2, 2'b00, 3, 32'hCAFEF00D);
    idle();
    force_lo = 1'b1;
    fork
      wr(32'h14, 3'd2, 32'h0BADF00D, 2'b00, 3);
      begin
        repeat (3) @(posedge hclk);
        #2 force_lo = 1'b0;
      end
    join
    rd(32'h14, 3'd2, 2'b00, 3, 32'h0BADF00D);
    idle();

    // WAIT_CYC = 5: reset in the middle of a write's wait states
    cur = 2;
    wr(32'h30, 3'd2, 32'h11112222, 2'b00, 5);
    rd(32'h30, 3'd2, 2'b00, 5, 32'h11112222);
    idle();
    xfer(1'b1, 32'h30, 3'd2, 32'h99999999, 2'b00, 5, 32'd0, 1'b1);
    hsel_v = 3'b000;
    htrans = 2'b00;
    repeat (2) @(posedge hclk);
    #1 hrest = 1'b1;
    @(posedge hclk);
    #1 hrest = 1'b0;
    hwdata = 32'd0;
    rd(32'h30, 3'd2, 2'b00, 5, 32'h11112222);
    idle();

    repeat (3) @(posedge hclk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/eva_ahb_sram_slv.md
EVA_AHB_SRAM_SLV -- requirements
Module: eva_ahb_sram_slv

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; array depth is 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYC, default 0, range 0..7; wait states inserted in every OKAY data phase.
REQ-003 hclk  in  1  single clock; all state updates on rising edge.
REQ-004 hrest  in  1  reset, synchronous, active-high.
REQ-005 hsel  in  1  slave select, address-phase qualifier.
REQ-006 htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-007 hwrite  in  1  1=write, 0=read.
REQ-008 haddr  in  32  byte address.
REQ-009 hsize  in  3  0=byte, 1=half, 2=word; 3..7 illegal.
REQ-010 hwdata  in  32  write data, valid in data phase.
REQ-011 hready_in  in  1  bus HREADY; address phase sampled only when high.
REQ-012 hready_out  out  1  data-phase completion from this slave.
REQ-013 hresp  out  2  00=OKAY, 01=ERROR.
REQ-014 hrdata  out  32  read data, valid when a read data phase completes.

Function
REQ-015 Transfer accepted when hsel & htrans[1] & hready_in at a rising edge; haddr, hwrite, hsize latched as data-phase control.
REQ-016 IDLE/BUSY or unselected address phase: next data phase OKAY, zero wait, no array access.
REQ-017 Accepted transfer is ERROR when any of: haddr[31:ADDR_W+2] != 0; hsize > 2; hsize=1 with haddr[0]=1; hsize=2 with haddr[1:0] != 0.
REQ-018 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-019 IDLE: hready_out=1, hresp=00; on accepted OKAY transfer -> WAIT if WAIT_CYC>0 (counter loaded WAIT_CYC-1), else stays IDLE with data phase completing next cycle.
REQ-020 IDLE on accepted ERROR transfer -> ERR1.
REQ-021 WAIT: hready_out=0, hresp=00; counter decrements each cycle; at counter=0 -> IDLE, data phase completes in the following cycle (total WAIT_CYC low cycles).
REQ-022 ERR1: hready_out=0, hresp=01, exactly one cycle -> ERR2.
REQ-023 ERR2: hready_out=1, hresp=01, one cycle; address phase in this cycle accepted per REQ-015 and next state chosen as from IDLE.
REQ-024 Write commit: on the cycle the OKAY write data phase completes (hready_out=1), byte lanes selected by latched size/haddr[1:0] updated from hwdata, little-endian (lane n = hwdata[8n+7:8n]); other lanes unchanged.
REQ-025 Read: hrdata = full array word at latched word address while an OKAY read data phase completes; 0 in all other cycles.
REQ-026 Write data phase followed by read of same word in the next address phase returns the newly written data (commit precedes read).
REQ-027 ERROR transfers never modify the array; hrdata=0 during ERR1/ERR2.
REQ-028 Back-to-back transfers with WAIT_CYC=0 sustain one transfer per cycle.
REQ-029 Address phase presented while hready_in=0 is ignored; master holds it until hready_in=1.

Reset
REQ-030 While hrest=1: state IDLE, wait counter 0, pending data phase cleared, hready_out=1, hresp=00, hrdata=0.
REQ-031 Reset during WAIT/ERR1/ERR2 or a pending write data phase aborts it; pending write not committed.
REQ-032 Array contents not reset; read before any write returns unspecified data.

Verification
REQ-033 WAIT_CYC=0: NONSEQ write 0x10 word 0xDEADBEEF, then read 0x10 -> hready_out stays 1, hresp=00, hrdata=0xDEADBEEF in read data phase.
REQ-034 Byte write 0x11 data 0x0000AB00 over word 0xDEADBEEF, read 0x10 -> 0xDEADABEF.
REQ-035 WAIT_CYC=3: read 0x10 -> hready_out low exactly 3 cycles, then high with hresp=00 and correct data.
REQ-036 Word write to 0x402 (misaligned) and to 0x400 with ADDR_W=8 (out of range) -> hready_out 0/1 with hresp=01 for 2 cycles each; later reads of 0x0 show array unchanged.
REQ-037 Back-to-back write 0x20, read 0x20, write 0x24, read 0x24 with WAIT_CYC=0 -> four transfers in four consecutive data phases, reads return written data.
REQ-038 Assert hrest during WAIT of a write (WAIT_CYC=5) -> next cycle hready_out=1, hresp=00; subsequent read shows old word.
